// File: rtl/usb_ls_tx_pkg.sv
// Shared types and line-state constants for the low-speed USB transmitter.
// Line levels are {dp, dm}; low-speed idle (J) has dm high.
package usb_ls_tx_pkg;

  typedef struct packed {
    logic dp;
    logic dm;
  } d_port_t;

  localparam d_port_t LINE_J   = d_port_t'(2'b01);
  localparam d_port_t LINE_K   = d_port_t'(2'b10);
  localparam d_port_t LINE_SE0 = d_port_t'(2'b00);

  localparam logic [7:0] SYNC_PATTERN = 8'h80;
  localparam logic [2:0] STUFF_RUN    = 3'd6;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    EOP_SE0,
    EOP_J
  } tx_state_t;

endpackage

// File: rtl/usb_ls_nrzi_stuff.sv
// Bit stuffer plus NRZI encoder; level 0 = J, 1 = K.
// A strobe while stall is high emits a stuffed 0 and does not consume bit_in.
module usb_ls_nrzi_stuff
  import usb_ls_tx_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic strobe,
  input  logic bit_in,
  output logic stall,
  output logic level
);

  logic [2:0] ones;

  assign stall = (ones == STUFF_RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      level <= 1'b0;
      ones  <= '0;
    end else if (start) begin
      // first bit of a packet is encoded against J
      level <= ~bit_in;
      ones  <= bit_in ? 3'd1 : 3'd0;
    end else if (strobe) begin
      if (stall) begin
        level <= ~level;
        ones  <= '0;
      end else if (bit_in) begin
        ones  <= ones + 3'd1;
      end else begin
        level <= ~level;
        ones  <= '0;
      end
    end
  end

endmodule

// File: rtl/usb_ls_tx.sv
// Low-speed USB packet transmitter: SYNC, LSB-first data with
// bit stuffing and NRZI, then SE0 SE0 J end of packet.
module usb_ls_tx
  import usb_ls_tx_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_err,
  output logic [1:0] d_o,
  output logic       d_en
);

  localparam int CW = $clog2(CLK_DIV);

  tx_state_t  state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0] bitn, bitn_nx, bitn_inc;
  logic [7:0] shift, shift_nx;
  logic [7:0] hold, hold_nx;
  logic       hold_full, hold_full_nx;
  logic       hold_last, hold_last_nx;
  logic       last_taken, last_taken_nx;
  logic       cur_last, cur_last_nx;
  logic       err, err_nx;
  logic       accept, bit_end, load;
  logic       start, emit, bit_nx;
  logic       stall, level;
  d_port_t    line;

  assign tx_ready = !hold_full && !last_taken
                 && state != EOP_SE0 && state != EOP_J;
  assign accept   = tx_valid && tx_ready;
  assign bit_end  = (cnt == CW'(CLK_DIV - 1));
  assign bitn_inc = bitn + 3'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bitn       <= '0;
      shift      <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      hold_last  <= 1'b0;
      last_taken <= 1'b0;
      cur_last   <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      bitn       <= bitn_nx;
      shift      <= shift_nx;
      hold       <= hold_nx;
      hold_full  <= hold_full_nx;
      hold_last  <= hold_last_nx;
      last_taken <= last_taken_nx;
      cur_last   <= cur_last_nx;
      err        <= err_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    cnt_nx        = (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
    bitn_nx       = bitn;
    shift_nx      = shift;
    hold_nx       = hold;
    hold_full_nx  = hold_full;
    hold_last_nx  = hold_last;
    last_taken_nx = last_taken;
    cur_last_nx   = cur_last;
    err_nx        = err;
    load          = 1'b0;
    start         = 1'b0;
    emit          = 1'b0;
    bit_nx        = 1'b0;

    if (accept) begin
      hold_nx       = tx_data;
      hold_full_nx  = 1'b1;
      hold_last_nx  = tx_last;
      last_taken_nx = last_taken | tx_last;
    end

    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nx = SYNC;
          start    = 1'b1;
          bit_nx   = SYNC_PATTERN[0];
          bitn_nx  = '0;
          err_nx   = 1'b0;
        end
      end
      SYNC: begin
        if (bit_end) begin
          if (bitn != 3'd7) begin
            emit    = 1'b1;
            bit_nx  = SYNC_PATTERN[bitn_inc];
            bitn_nx = bitn_inc;
          end else begin
            state_nx = DATA;
            load     = 1'b1;
          end
        end
      end
      DATA: begin
        // a pending stuff bit goes out before any byte-boundary decision
        if (bit_end) begin
          if (stall) begin
            emit = 1'b1;
          end else if (bitn != 3'd7) begin
            emit    = 1'b1;
            bit_nx  = shift[bitn_inc];
            bitn_nx = bitn_inc;
          end else if (cur_last) begin
            state_nx = EOP_SE0;
            bitn_nx  = '0;
          end else if (hold_full) begin
            load = 1'b1;
          end else begin
            state_nx = EOP_SE0;
            bitn_nx  = '0;
            err_nx   = 1'b1;
          end
        end
      end
      EOP_SE0: begin
        if (bit_end) begin
          if (bitn == 3'd1) state_nx = EOP_J;
          else              bitn_nx  = bitn_inc;
        end
      end
      EOP_J: begin
        if (bit_end) begin
          state_nx      = IDLE;
          last_taken_nx = 1'b0;
          cur_last_nx   = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (load) begin
      emit         = 1'b1;
      shift_nx     = hold;
      bit_nx       = hold[0];
      bitn_nx      = '0;
      cur_last_nx  = hold_last;
      hold_full_nx = 1'b0;
    end
  end

  usb_ls_nrzi_stuff u_nrzi (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .strobe (emit),
    .bit_in (bit_nx),
    .stall  (stall),
    .level  (level)
  );

  always_comb begin
    line = LINE_J;
    unique case (state)
      SYNC, DATA: line = level ? LINE_K : LINE_J;
      EOP_SE0:    line = LINE_SE0;
      default:    line = LINE_J;
    endcase
  end

  assign d_o     = line;
  assign d_en    = (state != IDLE);
  assign tx_busy = (state != IDLE);
  assign tx_err  = err;

endmodule
